// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying a payload and a control bundle under valid/ready flow control.
// Supports an optional two-entry skid buffer, a synchronous flush, and saturating flush/stall counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 10,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit             USE_SKID = (SKID != 32'd0);
  localparam bit             CLR_DATA = (CLEAR_DATA != 32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  logic              m_v_q, m_v_d, s_v_q, s_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic [CTRL_W-1:0] m_c_q, m_c_d, s_c_q, s_c_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;
  logic              accept_s, pop_s, in_ready_s, discard_s;
  occ_e              occ_s;

  assign in_ready_s = USE_SKID ? in_ready_q : (~m_v_q | out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign pop_s      = m_v_q & out_ready;
  // A head that pops during a flush still leaves normally, so it is not a discard.
  assign discard_s  = (m_v_q & ~pop_s) | s_v_q | accept_s;

  // Occupancy decode from the valid bits.
  always_comb begin
    if (s_v_q) begin
      occ_s = OCC_FULL;
    end else if (m_v_q) begin
      occ_s = OCC_ONE;
    end else begin
      occ_s = OCC_EMPTY;
    end
  end

  // Storage next-state: control is zeroed whenever its valid bit clears.
  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    m_c_d = m_c_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    s_c_d = s_c_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
      m_c_d = '0;
      s_c_d = '0;
      if (CLR_DATA) begin
        m_d_d = '0;
        s_d_d = '0;
      end else begin
        m_d_d = m_d_q;
        s_d_d = s_d_q;
      end
    end else if (USE_SKID) begin
      case (occ_s)
        OCC_EMPTY: begin
          if (accept_s) begin
            m_v_d = 1'b1;
            m_d_d = in_data;
            m_c_d = in_ctrl;
          end else begin
            m_v_d = 1'b0;
          end
        end
        OCC_ONE: begin
          if (accept_s && pop_s) begin
            m_d_d = in_data;
            m_c_d = in_ctrl;
          end else if (accept_s) begin
            s_v_d = 1'b1;
            s_d_d = in_data;
            s_c_d = in_ctrl;
          end else if (pop_s) begin
            m_v_d = 1'b0;
            m_c_d = '0;
          end else begin
            m_v_d = 1'b1;
          end
        end
        OCC_FULL: begin
          if (pop_s) begin
            m_d_d = s_d_q;
            m_c_d = s_c_q;
            s_v_d = 1'b0;
            s_c_d = '0;
          end else begin
            s_v_d = 1'b1;
          end
        end
        default: begin
          m_v_d = 1'b0;
          s_v_d = 1'b0;
          m_c_d = '0;
          s_c_d = '0;
        end
      endcase
    end else begin
      if (accept_s) begin
        m_v_d = 1'b1;
        m_d_d = in_data;
        m_c_d = in_ctrl;
      end else if (pop_s) begin
        m_v_d = 1'b0;
        m_c_d = '0;
      end else begin
        m_v_d = m_v_q;
      end
    end
  end

  // Registered in_ready and saturating profiling counters.
  always_comb begin
    in_ready_d  = ~s_v_d;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush && discard_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (m_v_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_v_q       <= 1'b0;
      m_d_q       <= '0;
      m_c_q       <= '0;
      s_v_q       <= 1'b0;
      s_d_q       <= '0;
      s_c_q       <= '0;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_v_q       <= m_v_d;
      m_d_q       <= m_d_d;
      m_c_q       <= m_c_d;
      s_v_q       <= s_v_d;
      s_d_q       <= s_d_d;
      s_c_q       <= s_c_d;
      in_ready_q  <= in_ready_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = m_v_q;
  assign out_data  = m_d_q;
  assign out_ctrl  = m_c_q;
  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, single-entry mode, and a 2-bit-counter skid instance
// that shares stimulus with the skid instance to exercise counter saturation.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // skid instances (u_skid and u_sat share inputs)
  logic        iv = 1'b0, fl = 1'b0, ordy = 1'b0;
  logic [15:0] id = 16'h0;
  logic [9:0]  ic = 10'h0;
  logic        s_ir, s_ov, c_ir, c_ov;
  logic [15:0] s_od, c_od, s_fc, s_sc;
  logic [9:0]  s_oc, c_oc;
  logic [1:0]  c_fc, c_sc;

  // single-entry instance
  logic        iv0 = 1'b0, fl0 = 1'b0, ordy0 = 1'b0;
  logic [15:0] id0 = 16'h0;
  logic [9:0]  ic0 = 10'h0;
  logic        z_ir, z_ov;
  logic [15:0] z_od, z_fc, z_sc;
  logic [9:0]  z_oc;

  int err_cnt = 0;
  int chk_cnt = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .SKID(1), .CLEAR_DATA(0), .CNT_W(16)) u_skid (
    .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(s_ir), .in_data(id), .in_ctrl(ic),
    .flush(fl), .out_valid(s_ov), .out_ready(ordy), .out_data(s_od), .out_ctrl(s_oc),
    .flush_cnt(s_fc), .stall_cnt(s_sc));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .SKID(1), .CLEAR_DATA(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(c_ir), .in_data(id), .in_ctrl(ic),
    .flush(fl), .out_valid(c_ov), .out_ready(ordy), .out_data(c_od), .out_ctrl(c_oc),
    .flush_cnt(c_fc), .stall_cnt(c_sc));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u_single (
    .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(z_ir), .in_data(id0), .in_ctrl(ic0),
    .flush(fl0), .out_valid(z_ov), .out_ready(ordy0), .out_data(z_od), .out_ctrl(z_oc),
    .flush_cnt(z_fc), .stall_cnt(z_sc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic r, input logic f);
    iv = v; ic = c; id = {6'h0, c}; ordy = r; fl = f;
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 32'(s_ov), 32'd0);
    check("rst_od", 32'(s_od), 32'd0);
    check("rst_oc", 32'(s_oc), 32'd0);
    check("rst_ir", 32'(s_ir), 32'd1);
    check("rst_fc", 32'(s_fc), 32'd0);
    check("rst_sc", 32'(s_sc), 32'd0);
    reset_n = 1'b1;

    // streaming, ctrl 1..8 back to back
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 10'(k), 1'b1, 1'b0);
      tick();
      check("str_oc", 32'(s_oc), 32'(k));
      check("str_ir", 32'(s_ir), 32'd1);
    end
    drive(1'b0, 10'h0, 1'b1, 1'b0);
    tick();
    check("str_end_ov", 32'(s_ov), 32'd0);
    check("str_sc", 32'(s_sc), 32'd0);

    // backpressure: A held, B into skid
    drive(1'b1, 10'h00A, 1'b0, 1'b0);
    tick();
    check("bp_a_oc", 32'(s_oc), 32'h00A);
    check("bp_a_od", 32'(s_od), 32'h000A);
    check("bp_a_ir", 32'(s_ir), 32'd1);
    drive(1'b1, 10'h00B, 1'b0, 1'b0);
    tick();
    check("bp_full_ir", 32'(s_ir), 32'd0);
    check("bp_full_oc", 32'(s_oc), 32'h00A);
    check("bp_sc1", 32'(s_sc), 32'd1);
    drive(1'b0, 10'h0, 1'b0, 1'b0);
    tick();
    check("bp_hold_oc", 32'(s_oc), 32'h00A);
    check("bp_sc2", 32'(s_sc), 32'd2);
    drive(1'b0, 10'h0, 1'b1, 1'b0);
    tick();
    check("bp_b_oc", 32'(s_oc), 32'h00B);
    check("bp_b_ov", 32'(s_ov), 32'd1);
    check("bp_b_ir", 32'(s_ir), 32'd1);
    tick();
    check("bp_drain_ov", 32'(s_ov), 32'd0);
    check("bp_sc_end", 32'(s_sc), 32'd2);
    check("sat_sc2", 32'(c_sc), 32'd2);

    // flush in FULL with C offered
    drive(1'b1, 10'h00A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 10'h00B, 1'b0, 1'b0);
    tick();
    check("fl_pre_ir", 32'(s_ir), 32'd0);
    drive(1'b1, 10'h00C, 1'b0, 1'b1);
    tick();
    check("fl_ov", 32'(s_ov), 32'd0);
    check("fl_oc", 32'(s_oc), 32'd0);
    check("fl_ir", 32'(s_ir), 32'd1);
    check("fl_fc", 32'(s_fc), 32'd1);
    check("fl_sc4", 32'(s_sc), 32'd4);
    check("sat_sc3", 32'(c_sc), 32'd3);
    check("sat_fc", 32'(c_fc), 32'd1);
    drive(1'b0, 10'h0, 1'b1, 1'b0);
    tick();
    check("fl_no_c", 32'(s_ov), 32'd0);

    // flush while empty, nothing offered
    drive(1'b0, 10'h0, 1'b1, 1'b1);
    tick();
    check("fle_fc", 32'(s_fc), 32'd1);
    drive(1'b1, 10'h03D, 1'b1, 1'b0);
    tick();
    check("fle_next_oc", 32'(s_oc), 32'h03D);
    check("fle_next_ov", 32'(s_ov), 32'd1);
    drive(1'b0, 10'h0, 1'b1, 1'b0);
    tick();
    // flush while empty discarding an incoming beat
    drive(1'b1, 10'h002, 1'b1, 1'b1);
    tick();
    check("fli_ov", 32'(s_ov), 32'd0);
    check("fli_fc", 32'(s_fc), 32'd2);
    drive(1'b0, 10'h0, 1'b1, 1'b0);

    // single-entry mode
    iv0 = 1'b1; ic0 = 10'h011; id0 = 16'h1111; ordy0 = 1'b0;
    #1;
    check("se_ir_empty", 32'(z_ir), 32'd1);
    tick();
    check("se_oc1", 32'(z_oc), 32'h011);
    check("se_od1", 32'(z_od), 32'h1111);
    ic0 = 10'h022; id0 = 16'h2222;
    #1;
    check("se_ir_blocked", 32'(z_ir), 32'd0);
    tick();
    check("se_hold", 32'(z_oc), 32'h011);
    ordy0 = 1'b1;
    #1;
    check("se_ir_open", 32'(z_ir), 32'd1);
    tick();
    check("se_replace", 32'(z_oc), 32'h022);
    check("se_ov", 32'(z_ov), 32'd1);
    iv0 = 1'b0;
    tick();
    check("se_drain_ov", 32'(z_ov), 32'd0);
    check("se_drain_oc", 32'(z_oc), 32'd0);
    check("se_sc", 32'(z_sc), 32'd1);

    // async reset while FULL
    drive(1'b1, 10'h00A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 10'h00B, 1'b0, 1'b0);
    tick();
    drive(1'b0, 10'h0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_ov", 32'(s_ov), 32'd0);
    check("ar_oc", 32'(s_oc), 32'd0);
    check("ar_ir", 32'(s_ir), 32'd1);
    check("ar_fc", 32'(s_fc), 32'd0);
    check("ar_sc", 32'(s_sc), 32'd0);
    check("ar_sat_sc", 32'(c_sc), 32'd0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 10'h007, 1'b1, 1'b0);
    tick();
    check("ar_resume_oc", 32'(s_oc), 32'h007);
    check("ar_resume_ov", 32'(s_ov), 32'd1);
    drive(1'b0, 10'h0, 1'b1, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
